// File: rtl/mux8to1_rr.sv
// mux8to1_rr: eight-lane valid/ready merge onto one registered output stream.
// Each output word carries the 3-bit source lane code in sel, which is the
// select code for the downstream demux1to8.
// Optional build macro: MUX8TO1_FIXED_PRIO_EN
//   defined   -> fixed priority grant, lane 0 highest, no rotating pointer
//   undefined -> round-robin grant starting from ptr (default)
module mux8to1_rr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out,
  output logic [2:0]         sel,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e     state;
  logic [2:0] start;
  logic [2:0] grant;
  logic [2:0] idx;
  logic       any_valid;
  logic       load;

`ifdef MUX8TO1_FIXED_PRIO_EN
  // Fixed priority: the search always begins at lane 0.
  assign start = 3'd0;
`else
  logic [2:0] ptr;

  // Round-robin pointer: advances past the granted lane on every load only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 3'd0;
    end else if (load) begin
      ptr <= grant + 3'd1;
    end
  end

  assign start = ptr;
`endif

  // Grant: first valid lane at or after start, wrapping mod 8. Scanning from
  // the farthest offset down lets the nearest valid lane win last.
  always_comb begin
    grant = start;
    idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (in_valid[idx]) begin
        grant = idx;
      end
    end
  end

  assign any_valid = |in_valid;
  // A word is taken when the output register is free or being drained this cycle.
  assign load      = ~rst & any_valid & ((state == EMPTY) | out_ready);
  assign in_ready  = load ? (8'b1 << grant) : 8'h00;
  assign out_valid = (state == FULL);

  // Output register state machine; out/sel hold their last values when emptying.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      out   <= '0;
      sel   <= 3'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
            out   <= in[32'(grant) * WIDTH +: WIDTH];
            sel   <= grant;
          end
        end
        FULL: begin
          if (load) begin
            state <= FULL;
            out   <= in[32'(grant) * WIDTH +: WIDTH];
            sel   <= grant;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8to1_rr.sv
// tb_mux8to1_rr: directed vectors with hand-computed expectations for mux8to1_rr
// (WIDTH=4, lane i carries 4'h8+i unless a test overrides it).
module tb_mux8to1_rr;

  localparam int unsigned WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] din;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out;
  logic [2:0]         sel;
  logic               out_ready;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] LANE_DATA = 32'hFEDC_BA98;

  mux8to1_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (din),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .sel       (sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected sel for the k-th load of an all-valid stream started at ptr=0.
  function automatic logic [2:0] rr_sel(input int k);
`ifdef MUX8TO1_FIXED_PRIO_EN
    return 3'd0;
`else
    return 3'(k % 8);
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] exp_s;
  logic [2:0] exp_wrap [3];

  initial begin
    rst       = 1'b1;
    in_valid  = 8'hFF;
    din       = LANE_DATA;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h00);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_in_ready_hold", 32'(in_ready), 32'h00);

    // First grant after release goes to lane 0.
    rst = 1'b0;
    #1;
    check("first_grant_ready", 32'(in_ready), 32'h01);
    tick();
    check("first_grant_sel", 32'(sel), 32'd0);
    check("first_grant_out", 32'(out), 32'h8);
    check("first_grant_valid", 32'(out_valid), 32'd1);

    // Single lane 3 carrying data 1.
    din[3*WIDTH +: WIDTH] = 4'h1;
    in_valid = 8'h08;
    #1;
    check("single_ready", 32'(in_ready), 32'h08);
    tick();
    check("single_out", 32'(out), 32'h1);
    check("single_sel", 32'(sel), 32'd3);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_demux", 32'(out[0] ? (8'b1 << sel) : 8'h00), 32'h08);
    din = LANE_DATA;

    // Reset while FULL: word discarded, pointer back to 0.
    in_valid = 8'h00;
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Round-robin over 10 loads with all lanes valid.
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_s = rr_sel(k);
      #1;
      check($sformatf("rr_ready_%0d", k), 32'(in_ready), 32'(8'b1 << exp_s));
      tick();
      check($sformatf("rr_sel_%0d", k), 32'(sel), 32'(exp_s));
      check($sformatf("rr_out_%0d", k), 32'(out), 32'(4'h8 + 4'(exp_s)));
      check($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
    end

    // Skip and wrap: load lane 0 to set ptr=1, then lanes 7 and 0 requesting.
    do_reset();
    in_valid = 8'h01;
    tick();
    check("wrap_pre_sel", 32'(sel), 32'd0);
`ifdef MUX8TO1_FIXED_PRIO_EN
    exp_wrap = '{3'd0, 3'd0, 3'd0};
`else
    exp_wrap = '{3'd7, 3'd0, 3'd7};
`endif
    in_valid = 8'h81;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wrap_sel_%0d", k), 32'(sel), 32'(exp_wrap[k]));
      check($sformatf("wrap_out_%0d", k), 32'(out), 32'(4'h8 + 4'(exp_wrap[k])));
    end

    // Backpressure: FULL with sel=2, lanes 4 and 5 waiting.
    do_reset();
    in_valid = 8'h04;
    tick();
    check("bp_pre_sel", 32'(sel), 32'd2);
    out_ready = 1'b0;
    in_valid  = 8'h30;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'h00);
      tick();
      check($sformatf("bp_sel_%0d", k), 32'(sel), 32'd2);
      check($sformatf("bp_out_%0d", k), 32'(out), 32'hA);
      check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h10);
    tick();
    check("bp_release_sel", 32'(sel), 32'd4);
    check("bp_release_out", 32'(out), 32'hC);
    check("bp_release_valid", 32'(out_valid), 32'd1);

    // Drain to empty: out/sel keep their last values.
    in_valid = 8'h00;
    #1;
    check("drain_ready", 32'(in_ready), 32'h00);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_sel", 32'(sel), 32'd4);
    check("drain_out", 32'(out), 32'hC);

    // EMPTY loads regardless of out_ready.
    out_ready = 1'b0;
    in_valid  = 8'h20;
    #1;
    check("empty_load_ready", 32'(in_ready), 32'h20);
    tick();
    check("empty_load_sel", 32'(sel), 32'd5);
    check("empty_load_valid", 32'(out_valid), 32'd1);

    // Reset while FULL, then the next grant starts from lane 0 again.
    in_valid = 8'h00;
    rst = 1'b1;
    tick();
    check("full_rst_valid", 32'(out_valid), 32'd0);
    check("full_rst_sel", 32'(sel), 32'd0);
    check("full_rst_out", 32'(out), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 8'hFF;
    #1;
    check("full_rst_ptr", 32'(in_ready), 32'h01);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8to1_rr.md
# mux8to1_rr

Eight-channel round-robin time-division multiplexer: the transmit-side counterpart of the 1-to-8 demultiplexer. It merges up to eight valid/ready input lanes onto one registered output stream. Each output word carries the 3-bit `sel` code of its source lane, so a downstream `demux1to8` driven by that `sel` routes every word back to its original channel. It sits directly upstream of the demux on the shared link.

## Interface
- `WIDTH`, default 1: data bits per lane and on the output.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  8  per-lane request; bit i = lane i.
- `in`  input  8*WIDTH  lane data; lane i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  output  8  per-lane accept; one-hot or zero.
- `out_valid`  output  1  output register holds a word.
- `out`  output  WIDTH  output word.
- `sel`  output  3  source lane index of `out`; this is the demux select code.
- `out_ready`  input  1  downstream accepts the word this cycle.

## Operation
- Lane transfer occurs when `in_valid[i] & in_ready[i]` is high at a rising edge. Output transfer occurs when `out_valid & out_ready` is high.
- The output register state machine has two states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- Transitions:
  - EMPTY, any `in_valid` high → capture the granted lane, go to FULL.
  - EMPTY, no `in_valid` → stay in EMPTY.
  - FULL, `out_ready`=0 → stay in FULL. `out` and `sel` are held stable.
  - FULL, `out_ready`=1, any `in_valid` high → capture a new word, stay in FULL. Back-to-back transfer, no bubble.
  - FULL, `out_ready`=1, no `in_valid` → go to EMPTY.
- Load enable: `load = (EMPTY | out_ready) & |in_valid`.
- Grant is combinational round-robin from a 3-bit pointer `ptr`.
  - The granted lane is the first lane with `in_valid` set, searching `ptr`, `ptr+1`, … `ptr+7`, all mod 8.
- `in_ready[g] = load` for the granted lane g. All other `in_ready` bits are 0.
- On load:
  - `out` ← lane g data.
  - `sel` ← g.
  - `ptr` ← g+1 mod 8. Lane 7 wraps to 0.
- `ptr` changes only on load.
- `in_ready` never depends on `in_valid` of the same lane being deasserted later. Lanes must hold data and valid until accepted.
- `out` and `sel` are not cleared on going to EMPTY. They keep their last values.

## Timing
- Reset values:
  - `out_valid`=0, `out`=0, `sel`=0, `ptr`=0.
  - `in_ready`=8'h00 while `rst` is high. It is gated combinationally by `rst`.
- Latency: a lane accepted at edge N appears on `out`/`sel` with `out_valid`=1 immediately after edge N, so it is visible in cycle N+1.
- Throughput: one word per cycle while `out_ready` stays high and requests are present.
- Fairness: with all eight lanes continuously valid, the grant order is ptr, ptr+1, … with no lane granted twice in any 8 consecutive loads.
- Simultaneous events: an output drain and a new load in the same cycle replace the word. There is no loss and no duplicate.
- Reset mid-operation: a held word is discarded, `out_valid` drops on the next edge, and `ptr` returns to 0.

## Configuration
- `MUX8TO1_FIXED_PRIO_EN`
  - Defined: grant is fixed priority with lane 0 highest and lane 7 lowest. `ptr` is not implemented and the search always starts at lane 0.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=8'hFF → `out_valid`=0, `out`=0, `sel`=0, `in_ready`=0. After release, the first grant goes to lane 0.
- Single lane, WIDTH=1: `in_valid`=8'h08, lane 3 data=1, `out_ready`=1 → `in_ready`=8'h08 for one cycle; next cycle `out`=1, `sel`=3'b011, `out_valid`=1. Feeding `out`/`sel` to `demux1to8` yields 8'b0000_1000.
- Round-robin: `in_valid`=8'hFF held, `out_ready`=1, 10 cycles → `sel` sequence 0,1,2,3,4,5,6,7,0,1 with `out_valid` high every cycle. With `MUX8TO1_FIXED_PRIO_EN` defined → `sel`=0 every cycle.
- Skip and wrap: `in_valid`=8'h81, `ptr`=1 → lane 7 is granted first (`sel`=7), then lane 0 (`sel`=0), then lane 7.
- Backpressure: FULL with `sel`=2, `out_ready`=0 for 3 cycles, `in_valid`=8'h30 → `in_ready`=0 and `out`/`sel` are stable. When `out_ready` rises, lane 4 is loaded the same cycle with no bubble.
- Drain to empty: FULL, `out_ready`=1, `in_valid`=0 → `out_valid`=0 next cycle with `out`/`sel` unchanged. A reset asserted while FULL gives `out_valid`=0 and `ptr`=0 after one edge.
